// File: rtl/free_list.sv
// Free physical-register tag FIFO for rename.
// Allocates to dispatch, refills from retire, rewinds head on rollback.
`ifndef FL_ENTRY_NUM
`define FL_ENTRY_NUM 32
`endif

package free_list_pkg;
  localparam int DP_NUM       = 2;
  localparam int RT_NUM       = 2;
  localparam int FL_ENTRY_NUM = `FL_ENTRY_NUM;
  localparam int PREG_NUM     = 64;
  localparam int FL_IDX       = $clog2(FL_ENTRY_NUM);
  localparam int PREG_IDX     = $clog2(PREG_NUM);

  typedef struct packed {
    logic [1:0] dp_num;
  } DP_FL;

  typedef struct packed {
    logic [RT_NUM-1:0][PREG_IDX-1:0] phy_reg;
    logic [1:0]                      rt_num;
  } ROB_FL;

  typedef struct packed {
    logic [PREG_IDX-1:0] tag;
  } ROB_VFL;

  typedef struct packed {
    logic [1:0]                      avail_num;
    logic [DP_NUM-1:0][PREG_IDX-1:0] tag;
  } FL_DP;

  typedef struct packed {
    logic [PREG_IDX-1:0] tag;
  } FL_ENTRY;
endpackage

module free_list
  import free_list_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rollback_i,
  input  DP_FL                           dp_fl_i,
  input  ROB_FL                          rob_fl_i,
  input  ROB_VFL                         vfl_i,
  output FL_DP                           fl_dp_o,
  output FL_ENTRY                        fl_entry      [FL_ENTRY_NUM],
  output FL_ENTRY                        next_fl_entry [FL_ENTRY_NUM],
  output logic [FL_IDX-1:0]              fl_rollback_idx,
  output logic [FL_IDX-1:0]              head,
  output logic [FL_IDX-1:0]              next_head,
  output logic [FL_IDX-1:0]              tail,
  output logic [FL_IDX-1:0]              next_tail,
  output logic [DP_NUM-1:0][FL_IDX-1:0]  fl_idx
);

  localparam int N  = FL_ENTRY_NUM;
  localparam int CW = FL_IDX + 1;

  typedef logic [CW-1:0] cnt_t;

  FL_ENTRY           entry_q [N];
  FL_ENTRY           entry_d [N];
  logic [FL_IDX-1:0] head_q, head_d;
  logic [FL_IDX-1:0] tail_q, tail_d;
  cnt_t              count_q, count_d;
  cnt_t              dp_req, rt_req;
  cnt_t              pop, push, space;
  logic [FL_IDX-1:0] rb_idx;
  logic [FL_IDX-1:0] rb_cnt;
  logic              rb_hit;
  logic              rb_go;

  // Lowest-index entry holding the rollback tag
  always_comb begin
    rb_idx = '0;
    rb_hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (entry_q[i].tag == vfl_i.tag) begin
        rb_idx = FL_IDX'(i);
        rb_hit = 1'b1;
      end
    end
  end

  assign rb_go = rollback_i & rb_hit;

  // Clamp dispatch to occupancy and retire to free space
  always_comb begin
    dp_req = cnt_t'(dp_fl_i.dp_num);
    if (dp_req > cnt_t'(DP_NUM))
      dp_req = cnt_t'(DP_NUM);
    pop = (dp_req < count_q) ? dp_req : count_q;
    if (rb_go)
      pop = '0;
    rt_req = cnt_t'(rob_fl_i.rt_num);
    if (rt_req > cnt_t'(RT_NUM))
      rt_req = cnt_t'(RT_NUM);
    space = cnt_t'(N) - count_q + pop;
    push  = (rt_req < space) ? rt_req : space;
  end

  // Next entries, pointers and occupancy
  always_comb begin
    entry_d = entry_q;
    for (int i = 0; i < RT_NUM; i++) begin
      if (cnt_t'(i) < push)
        entry_d[tail_q + FL_IDX'(i)].tag = rob_fl_i.phy_reg[i];
    end
    tail_d  = tail_q + push[FL_IDX-1:0];
    head_d  = head_q + pop[FL_IDX-1:0];
    count_d = count_q - pop + push;
    rb_cnt  = tail_d - rb_idx;
    if (rb_go) begin
      head_d  = rb_idx;
      count_d = (rb_cnt == '0) ? cnt_t'(N) : {1'b0, rb_cnt};
    end
  end

  // State register; reset refills with the upper tag range
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N; i++)
        entry_q[i].tag <= PREG_IDX'(PREG_NUM - N + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= cnt_t'(N);
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Dispatch view and debug exports
  always_comb begin
    fl_dp_o.avail_num = (count_q > cnt_t'(DP_NUM)) ?
                        2'(DP_NUM) : count_q[1:0];
    for (int i = 0; i < DP_NUM; i++) begin
      fl_idx[i]         = head_q + FL_IDX'(i);
      fl_dp_o.tag[i]    = entry_q[head_q + FL_IDX'(i)].tag;
    end
  end

  assign fl_entry        = entry_q;
  assign next_fl_entry   = entry_d;
  assign fl_rollback_idx = rb_idx;
  assign head            = head_q;
  assign next_head       = head_d;
  assign tail            = tail_q;
  assign next_tail       = tail_d;

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list.
// Scoreboard of expected pointers/tags plus scenario checks.
module tb_free_list;
  import free_list_pkg::*;

  logic    clk_i = 1'b0;
  logic    rst_i;
  logic    rollback_i;
  DP_FL    dp_fl_i;
  ROB_FL   rob_fl_i;
  ROB_VFL  vfl_i;
  FL_DP    fl_dp_o;
  FL_ENTRY fl_entry      [FL_ENTRY_NUM];
  FL_ENTRY next_fl_entry [FL_ENTRY_NUM];
  logic [FL_IDX-1:0] fl_rollback_idx;
  logic [FL_IDX-1:0] head, next_head, tail, next_tail;
  logic [DP_NUM-1:0][FL_IDX-1:0] fl_idx;

  free_list dut (
    .clk_i(clk_i), .rst_i(rst_i), .rollback_i(rollback_i),
    .dp_fl_i(dp_fl_i), .rob_fl_i(rob_fl_i), .vfl_i(vfl_i),
    .fl_dp_o(fl_dp_o), .fl_entry(fl_entry),
    .next_fl_entry(next_fl_entry),
    .fl_rollback_idx(fl_rollback_idx),
    .head(head), .next_head(next_head),
    .tail(tail), .next_tail(next_tail), .fl_idx(fl_idx)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int head;
    int tail;
    int avail;
    int tag0;
    int tag1;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   m_entry [32];
  int   m_head, m_tail, m_count;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  // Reference update of the free list, expectation queued per cycle
  task automatic drive(int dp, int rt, int p0, int p1,
                       bit rb, int vt);
    int pop, push, rq, rr, idx, c;
    bit hit;
    exp_t e;
    @(negedge clk_i);
    dp_fl_i.dp_num      = 2'(dp);
    rob_fl_i.rt_num     = 2'(rt);
    rob_fl_i.phy_reg[0] = 6'(p0);
    rob_fl_i.phy_reg[1] = 6'(p1);
    rollback_i          = rb;
    vfl_i.tag           = 6'(vt);
    hit = 0;
    idx = 0;
    for (int i = 31; i >= 0; i--)
      if (m_entry[i] == vt) begin
        hit = 1;
        idx = i;
      end
    rq  = (dp > 2) ? 2 : dp;
    pop = (rq < m_count) ? rq : m_count;
    if (rb && hit) pop = 0;
    rr   = (rt > 2) ? 2 : rt;
    push = (rr < 32 - m_count + pop) ? rr : 32 - m_count + pop;
    if (push > 0) m_entry[m_tail] = p0;
    if (push > 1) m_entry[(m_tail + 1) % 32] = p1;
    m_tail  = (m_tail + push) % 32;
    m_head  = (m_head + pop) % 32;
    m_count = m_count - pop + push;
    if (rb && hit) begin
      m_head = idx;
      c = (m_tail - idx + 32) % 32;
      m_count = (c == 0) ? 32 : c;
    end
    e.head  = m_head;
    e.tail  = m_tail;
    e.avail = (m_count > 2) ? 2 : m_count;
    e.tag0  = m_entry[m_head];
    e.tag1  = m_entry[(m_head + 1) % 32];
    sb_q.push_back(e);
    @(posedge clk_i);
    #2;
  endtask

  // Scoreboard: compare registered state after each driven edge
  always @(posedge clk_i) begin
    if (rst_i && sb_q.size() > 0) begin
      #1;
      mon_e = sb_q.pop_front();
      tot_cnt++;
      if (int'(head) !== mon_e.head)
        $display("FAIL sb_head got %0d want %0d", head, mon_e.head);
      else pass_cnt++;
      tot_cnt++;
      if (int'(tail) !== mon_e.tail)
        $display("FAIL sb_tail got %0d want %0d", tail, mon_e.tail);
      else pass_cnt++;
      tot_cnt++;
      if (int'(fl_dp_o.avail_num) !== mon_e.avail)
        $display("FAIL sb_avail got %0d want %0d",
                 fl_dp_o.avail_num, mon_e.avail);
      else pass_cnt++;
      if (mon_e.avail > 0) begin
        tot_cnt++;
        if (int'(fl_dp_o.tag[0]) !== mon_e.tag0)
          $display("FAIL sb_tag0 got %0d want %0d",
                   fl_dp_o.tag[0], mon_e.tag0);
        else pass_cnt++;
      end
      if (mon_e.avail > 1) begin
        tot_cnt++;
        if (int'(fl_dp_o.tag[1]) !== mon_e.tag1)
          $display("FAIL sb_tag1 got %0d want %0d",
                   fl_dp_o.tag[1], mon_e.tag1);
        else pass_cnt++;
      end
    end
  end

  task automatic test_reset();
    rst_i      = 1'b0;
    rollback_i = 1'b0;
    dp_fl_i    = '0;
    rob_fl_i   = '0;
    vfl_i      = '0;
    repeat (2) @(posedge clk_i);
    #1;
    tot_cnt++;
    if (fl_dp_o.avail_num !== 2'd2)
      $display("FAIL rst_avail got %0d want 2", fl_dp_o.avail_num);
    else pass_cnt++;
    tot_cnt++;
    if (fl_dp_o.tag[0] !== 6'd32 || fl_dp_o.tag[1] !== 6'd33)
      $display("FAIL rst_tags got %0d/%0d want 32/33",
               fl_dp_o.tag[0], fl_dp_o.tag[1]);
    else pass_cnt++;
    tot_cnt++;
    if (head !== 5'd0 || tail !== 5'd0)
      $display("FAIL rst_ptr got %0d/%0d want 0/0", head, tail);
    else pass_cnt++;
    tot_cnt++;
    if (fl_idx !== {5'd1, 5'd0})
      $display("FAIL rst_fl_idx got %h want 020", fl_idx);
    else pass_cnt++;
    tot_cnt++;
    if (fl_entry[31].tag !== 6'd63)
      $display("FAIL rst_entry31 got %0d want 63", fl_entry[31].tag);
    else pass_cnt++;
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 32; i++) m_entry[i] = 32 + i;
    m_head  = 0;
    m_tail  = 0;
    m_count = 32;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    tot_cnt++;
    if (head !== 5'd0 || tail !== 5'd0)
      $display("FAIL idle_ptr got %0d/%0d want 0/0", head, tail);
    else pass_cnt++;
  endtask

  task automatic test_full_retire();
    drive(0, 2, 1, 2, 0, 0);
    tot_cnt++;
    if (tail !== 5'd0 || fl_entry[0].tag !== 6'd32)
      $display("FAIL full_drop got tail %0d e0 %0d want 0/32",
               tail, fl_entry[0].tag);
    else pass_cnt++;
  endtask

  task automatic test_dispatch();
    int want_h [3] = '{1, 3, 5};
    int want_t [3] = '{33, 35, 37};
    for (int k = 0; k < 3; k++) begin
      drive(k + 1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      tot_cnt++;
      if (int'(head) !== want_h[k])
        $display("FAIL dp%0d_head got %0d want %0d",
                 k + 1, head, want_h[k]);
      else pass_cnt++;
      tot_cnt++;
      if (int'(fl_dp_o.tag[0]) !== want_t[k] ||
          int'(fl_dp_o.tag[1]) !== want_t[k] + 1)
        $display("FAIL dp%0d_tags got %0d/%0d want %0d/%0d", k + 1,
                 fl_dp_o.tag[0], fl_dp_o.tag[1], want_t[k], want_t[k] + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_retire();
    drive(0, 3, 8, 9, 0, 0);
    tot_cnt++;
    if (fl_entry[0].tag !== 6'd8 || fl_entry[1].tag !== 6'd9)
      $display("FAIL rt_entries got %0d/%0d want 8/9",
               fl_entry[0].tag, fl_entry[1].tag);
    else pass_cnt++;
    tot_cnt++;
    if (tail !== 5'd2 || head !== 5'd5 || 5'(tail - head) !== 5'd29)
      $display("FAIL rt_ptr got h%0d t%0d want h5 t2", head, tail);
    else pass_cnt++;
  endtask

  task automatic test_rollback();
    drive(2, 0, 0, 0, 0, 0);
    tot_cnt++;
    if (head !== 5'd7)
      $display("FAIL rb_pre_head got %0d want 7", head);
    else pass_cnt++;
    drive(0, 0, 0, 0, 1, 0);
    tot_cnt++;
    if (head !== 5'd7 || fl_rollback_idx !== 5'd0)
      $display("FAIL rb_nomatch got h%0d idx%0d want 7/0",
               head, fl_rollback_idx);
    else pass_cnt++;
    drive(2, 0, 0, 0, 1, 36);
    tot_cnt++;
    if (fl_rollback_idx !== 5'd4)
      $display("FAIL rb_idx got %0d want 4", fl_rollback_idx);
    else pass_cnt++;
    tot_cnt++;
    if (head !== 5'd4 || 5'(tail - head) !== 5'd30)
      $display("FAIL rb_head got h%0d t%0d want h4 t2", head, tail);
    else pass_cnt++;
    tot_cnt++;
    if (fl_dp_o.tag[0] !== 6'd36 || fl_dp_o.tag[1] !== 6'd37)
      $display("FAIL rb_tags got %0d/%0d want 36/37",
               fl_dp_o.tag[0], fl_dp_o.tag[1]);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    int n = 0;
    bit saw1 = 0;
    logic [FL_IDX-1:0] h;
    drive(1, 0, 0, 0, 0, 0);
    while (fl_dp_o.avail_num != 2'd0 && n < 40) begin
      if (fl_dp_o.avail_num == 2'd1) saw1 = 1;
      drive(3, 0, 0, 0, 0, 0);
      n++;
    end
    tot_cnt++;
    if (n >= 40)
      $display("FAIL drain_timeout got %0d cycles want <40", n);
    else pass_cnt++;
    tot_cnt++;
    if (!saw1)
      $display("FAIL drain_avail1 got never want seen");
    else pass_cnt++;
    h = head;
    drive(3, 0, 0, 0, 0, 0);
    drive(3, 0, 0, 0, 0, 0);
    tot_cnt++;
    if (head !== h || head !== 5'd2 || next_head !== 5'd2)
      $display("FAIL drain_hold got %0d next %0d want 2", head, next_head);
    else pass_cnt++;
    tot_cnt++;
    if (fl_dp_o.avail_num !== 2'd0)
      $display("FAIL drain_empty got %0d want 0", fl_dp_o.avail_num);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive(2, 2, 10, 11, 0, 0);
    tot_cnt++;
    if (head !== 5'd2 || tail !== 5'd4)
      $display("FAIL b2b_ptr got h%0d t%0d want h2 t4", head, tail);
    else pass_cnt++;
    tot_cnt++;
    if (fl_dp_o.avail_num !== 2'd2 || fl_dp_o.tag[0] !== 6'd10 ||
        fl_dp_o.tag[1] !== 6'd11)
      $display("FAIL b2b_tags got %0d:%0d/%0d want 2:10/11",
               fl_dp_o.avail_num, fl_dp_o.tag[0], fl_dp_o.tag[1]);
    else pass_cnt++;
  endtask

  task automatic test_reset_override();
    @(negedge clk_i);
    rst_i               = 1'b0;
    dp_fl_i.dp_num      = 2'd2;
    rob_fl_i.rt_num     = 2'd2;
    rob_fl_i.phy_reg[0] = 6'd5;
    rob_fl_i.phy_reg[1] = 6'd6;
    rollback_i          = 1'b1;
    vfl_i.tag           = 6'd10;
    @(posedge clk_i);
    #1;
    tot_cnt++;
    if (head !== 5'd0 || tail !== 5'd0 || fl_dp_o.tag[0] !== 6'd32 ||
        fl_dp_o.avail_num !== 2'd2)
      $display("FAIL rst_override got h%0d t%0d tag%0d av%0d",
               head, tail, fl_dp_o.tag[0], fl_dp_o.avail_num);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_full_retire();
    test_dispatch();
    test_retire();
    test_rollback();
    test_drain();
    test_back_to_back();
    test_reset_override();
    repeat (2) @(posedge clk_i);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/free_list.md
# free_list

Circular FIFO of free physical-register tags for the rename stage of the out-of-order core. It hands up to DP_NUM free tags per cycle to dispatch, accepts up to RT_NUM tags released by retirement from the ROB, and on rollback restores its head pointer to the entry holding a ROB-supplied tag. Internal pointers and next-state values are exported as debug ports.

## Interface
- DP_NUM, 2: max tags allocated per cycle.
- RT_NUM, 2: max tags freed per cycle.
- FL_ENTRY_NUM, `FL_ENTRY_NUM (32): entries; FL_IDX = $clog2(FL_ENTRY_NUM).
- PREG_NUM, 64: physical registers; PREG_IDX = $clog2(PREG_NUM).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- rollback_i  in  1  restore head to the rob_vfl tag's entry this cycle.
- dp_fl_i  in  DP_FL  .dp_num[1:0]: tags requested by dispatch.
- rob_fl_i  in  ROB_FL  .phy_reg[RT_NUM][PREG_IDX]: freed tags; .rt_num[1:0]: count valid.
- vfl_i  in  ROB_VFL  .tag[PREG_IDX]: rollback target tag.
- fl_dp_o  out  FL_DP  .avail_num[1:0] = min(count, DP_NUM); .tag[DP_NUM][PREG_IDX] = entry[(head+i) mod N].tag.
- fl_entry  out  FL_ENTRY[N]  current entry array (.tag).
- next_fl_entry  out  FL_ENTRY[N]  next-cycle entry array.
- fl_rollback_idx  out  FL_IDX  index of the entry matching vfl_i.tag.
- head / next_head  out  FL_IDX  current / next read pointer.
- tail / next_tail  out  FL_IDX  current / next write pointer.
- fl_idx  out  DP_NUM×FL_IDX  (head+i) mod N, the entries driving fl_dp_o.tag[i].

## Operation
- State: entry array, head, tail, count (FL_IDX+1 bits, 0..N). Count disambiguates head==tail.
- Reset (rst_i==0 at posedge): entry[i].tag = PREG_NUM−N+i (32..63), head=0, tail=0, count=N.
- Dispatch: pop = min(dp_num, DP_NUM, count). dp_num=3 saturates to 2. Pop is limited by the current count; same-cycle retires do not count. head += pop mod N. Entries are not cleared on pop.
- Retire: req = min(rt_num, RT_NUM). push = min(req, N − count + pop). entry[(tail+i) mod N].tag = phy_reg[i] for i<push. tail += push mod N. Excess pushes are dropped.
- count_next = count − pop + push.
- Rollback:
  - fl_rollback_idx = lowest index i with entry[i].tag == vfl_i.tag, combinational and always driven. Value is 0 when there is no match.
  - When rollback_i=1 and a match exists: dispatch is ignored (pop=0), retire is still applied, head_next = match index, count_next = (tail_next − idx) mod N. A result of 0 means N (full).
  - When there is no match, head and count are unchanged apart from the retire.
- Wrap-around: all pointer arithmetic is modulo N, N a power of two.
- Empty list: avail_num=0; fl_dp_o.tag values are stale entries, don't care.

## Timing
- fl_dp_o, fl_idx, fl_rollback_idx and all next_* outputs are combinational from registered state and current inputs.
- Pop/push/rollback take effect at the posedge. Tags popped in cycle t are the fl_dp_o.tag values presented in cycle t.
- A retired tag becomes allocatable in the cycle after its push.
- Reset overrides rollback, dispatch and retire.
- Outputs after reset: avail_num=2, tag[0]=32, tag[1]=33, head=tail=0, fl_idx={1,0}.
- No handshake. Dispatch must not request more than avail_num; requests beyond it are clamped.

## Test plan
- Reset, then idle with dp_num=0, rt_num=0 → avail_num=2, tags 32/33, head=0, tail=0, pointers stable.
- dp_num=1, then 2, then 3, each followed by an idle cycle:
  - head → 1, 3, 5.
  - tags → 33/34, 35/36, 37/38.
  - The dp_num=3 request pops only 2.
- Retire:
  - Setup: head=5, count=27.
  - Stimulus: rt_num=3, phy_reg={8,9}.
  - Response: entry[0]=8, entry[1]=9, tail=2, count=29, head unchanged.
- Rollback:
  - Setup: dispatch 2 (head=7), then rollback_i with vfl tag 0.
  - Tag 0 absent → no change.
  - Then vfl tag 36 → fl_rollback_idx=4, head=4, count=30, tags 36/37.
- Drain:
  - dp_num=3 every cycle until avail_num becomes 1, then 0.
  - Further requests leave head fixed, and count never underflows.
- Empty list, dp_num=2 and rt_num=2 (tags 10, 11) in the same cycle → pop 0, push 2. Next cycle: avail_num=2, tags 10/11.
